// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: receives a framed image over a byte stream,
// writes it into IMEM, holds the MCU in reset while loading, then releases it.
// Optional inter-byte timeout is enabled with `define IMEM_LOADER_TIMEOUT_EN.
module imem_program_loader #(
  parameter int          ADDR_WIDTH     = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [7:0]            i_rxData,
  input  logic                  i_rxValid,
  output logic                  o_rxReady,
  output logic                  o_imemWe,
  output logic [ADDR_WIDTH-1:0] o_imemAddr,
  output logic [7:0]            o_imemData,
  output logic                  o_mcuReset,
  output logic [ADDR_WIDTH-1:0] o_resetPC,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  typedef enum logic [2:0] {
    IDLE, ADDR, LEN, DATA, CSUM, RELEASE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] baseAddr_q;
  logic [ADDR_WIDTH-1:0] wrAddr_q;
  logic [8:0]            remain_q;
  logic [7:0]            sum_q;
  logic                  rxReady_q;
  logic                  imemWe_q;
  logic [ADDR_WIDTH-1:0] imemAddr_q;
  logic [7:0]            imemData_q;
  logic                  mcuReset_q;
  logic [ADDR_WIDTH-1:0] resetPC_q;
  logic                  done_q;
  logic                  error_q;

  logic       accept_d;
  logic [7:0] sum_d;

  assign accept_d = i_rxValid && rxReady_q;
  assign sum_d    = sum_q + i_rxData;

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q;
  logic          midFrame_d;

  assign midFrame_d = (state_q == ADDR) || (state_q == LEN) ||
                      (state_q == DATA) || (state_q == CSUM);
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      baseAddr_q <= '0;
      wrAddr_q   <= '0;
      remain_q   <= '0;
      sum_q      <= '0;
      rxReady_q  <= 1'b0;
      imemWe_q   <= 1'b0;
      imemAddr_q <= '0;
      imemData_q <= '0;
      mcuReset_q <= 1'b1;
      resetPC_q  <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_TIMEOUT_EN
      tcnt_q     <= '0;
`endif
    end else begin
      imemWe_q  <= 1'b0;
      done_q    <= 1'b0;
      rxReady_q <= 1'b1;
`ifdef IMEM_LOADER_TIMEOUT_EN
      if (midFrame_d && !accept_d) tcnt_q <= tcnt_q + 1'b1;
      else                         tcnt_q <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (accept_d && i_rxData == SYNC_BYTE) begin
            state_q    <= ADDR;
            mcuReset_q <= 1'b1;
            error_q    <= 1'b0;
          end
        end
        ADDR: begin
          if (accept_d) begin
            baseAddr_q <= ADDR_WIDTH'(i_rxData);
            wrAddr_q   <= ADDR_WIDTH'(i_rxData);
            sum_q      <= i_rxData;
            state_q    <= LEN;
          end
        end
        LEN: begin
          if (accept_d) begin
            sum_q    <= sum_d;
            remain_q <= (i_rxData == 8'd0) ? 9'd256 : {1'b0, i_rxData};
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (accept_d) begin
            imemWe_q   <= 1'b1;
            imemAddr_q <= wrAddr_q;
            imemData_q <= i_rxData;
            wrAddr_q   <= wrAddr_q + 1'b1;
            sum_q      <= sum_d;
            remain_q   <= remain_q - 9'd1;
            if (remain_q == 9'd1) state_q <= CSUM;
          end
        end
        CSUM: begin
          if (accept_d) begin
            // resetPC is updated before the MCU is released so it is stable at release
            if (sum_d == 8'd0) begin
              resetPC_q <= baseAddr_q;
              rxReady_q <= 1'b0;
              state_q   <= RELEASE;
            end else begin
              error_q <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        RELEASE: begin
          done_q     <= 1'b1;
          mcuReset_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef IMEM_LOADER_TIMEOUT_EN
      if (midFrame_d && !accept_d && tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_q    <= IDLE;
        error_q    <= 1'b1;
        mcuReset_q <= 1'b1;
        tcnt_q     <= '0;
      end
`endif
    end
  end

  assign o_rxReady  = rxReady_q;
  assign o_imemWe   = imemWe_q;
  assign o_imemAddr = imemAddr_q;
  assign o_imemData = imemData_q;
  assign o_mcuReset = mcuReset_q;
  assign o_resetPC  = resetPC_q;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;
  assign o_error    = error_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard testbench for imem_program_loader: expected IMEM writes and release
// events are queued as frames are sent and compared when the DUT produces them.
module tb_imem_program_loader;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] rxData = 8'h00;
  logic       rxValid = 1'b0;
  logic       o_rxReady, o_imemWe, o_mcuReset, o_busy, o_done, o_error;
  logic [7:0] o_imemAddr, o_imemData, o_resetPC;

  int errors = 0;
  int checks = 0;

  logic [15:0] expWr[$];
  logic [7:0]  expDone[$];
  logic [7:0]  frameData[$];

  imem_program_loader #(
    .ADDR_WIDTH(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .i_rxData(rxData), .i_rxValid(rxValid), .o_rxReady(o_rxReady),
    .o_imemWe(o_imemWe), .o_imemAddr(o_imemAddr), .o_imemData(o_imemData),
    .o_mcuReset(o_mcuReset), .o_resetPC(o_resetPC),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 Clk = ~Clk;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Scoreboard consumer: every write and every done pulse must have been predicted
  always @(negedge Clk) begin
    if (Reset) begin
      if (o_imemWe) begin
        if (expWr.size() == 0) checkOutput("writeExpected", 32'(expWr.size() != 0), 32'd1);
        else checkOutput("imemWrite", {o_imemAddr, o_imemData}, expWr.pop_front());
      end
      if (o_done) begin
        if (expDone.size() == 0) checkOutput("doneExpected", 32'(expDone.size() != 0), 32'd1);
        else begin
          checkOutput("resetPC", o_resetPC, expDone.pop_front());
          checkOutput("mcuResetAtDone", o_mcuReset, 32'd0);
        end
      end
    end
  end

  // Drive one byte and hold it until the DUT accepts it
  task automatic applyStimulus(input logic [7:0] b);
    int guard;
    @(negedge Clk);
    rxData  = b;
    rxValid = 1'b1;
    guard   = 0;
    while (!o_rxReady && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 100) checkOutput("rxReadyTimeout", o_rxReady, 32'd1);
    @(posedge Clk);
    #1 rxValid = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] a, input logic [7:0] l, input logic [7:0] csumDelta);
    logic [7:0] sum;
    logic [7:0] c;
    int n;
    n   = (l == 8'd0) ? 256 : int'(l);
    sum = a + l;
    for (int i = 0; i < n; i++) begin
      sum = sum + frameData[i];
      expWr.push_back({8'(a + 8'(i)), frameData[i]});
    end
    c = 8'(8'd0 - sum) + csumDelta;
    if (csumDelta == 8'd0) expDone.push_back(a);
    applyStimulus(8'hA5);
    checkOutput("mcuResetOnSync", o_mcuReset, 32'd1);
    checkOutput("busyOnSync", o_busy, 32'd1);
    applyStimulus(a);
    applyStimulus(l);
    for (int i = 0; i < n; i++) applyStimulus(frameData[i]);
    applyStimulus(c);
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while ((expWr.size() != 0 || expDone.size() != 0) && guard < 40) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 40) checkOutput("drainTimeout", expWr.size() + expDone.size(), 32'd0);
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #100;
    checkOutput("rstMcuReset", o_mcuReset, 32'd1);
    checkOutput("rstRxReady", o_rxReady, 32'd0);
    checkOutput("rstImemWe", o_imemWe, 32'd0);
    checkOutput("rstResetPC", o_resetPC, 32'd0);
    checkOutput("rstBusy", o_busy, 32'd0);
    checkOutput("rstError", o_error, 32'd0);
    checkOutput("rstDone", o_done, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    checkOutput("idleRxReady", o_rxReady, 32'd1);
    checkOutput("idleMcuReset", o_mcuReset, 32'd1);
    checkOutput("idleResetPC", o_resetPC, 32'd0);

    frameData = {8'h11, 8'h22, 8'h33};
    sendFrame(8'h10, 8'h03, 8'h00);
    waitDrain();
    checkOutput("f1McuReset", o_mcuReset, 32'd0);
    checkOutput("f1ResetPC", o_resetPC, 32'h10);
    checkOutput("f1Busy", o_busy, 32'd0);

    frameData = {8'hAA, 8'hBB, 8'hCC};
    sendFrame(8'hFE, 8'h03, 8'h00);
    waitDrain();
    checkOutput("wrapResetPC", o_resetPC, 32'hFE);

    sendFrame(8'hFE, 8'h03, 8'h01);
    waitDrain();
    checkOutput("badError", o_error, 32'd1);
    checkOutput("badMcuReset", o_mcuReset, 32'd1);
    checkOutput("badBusy", o_busy, 32'd0);

    frameData = {8'h01, 8'h02};
    sendFrame(8'h40, 8'h02, 8'h00);
    waitDrain();
    checkOutput("recoverError", o_error, 32'd0);
    checkOutput("recoverMcuReset", o_mcuReset, 32'd0);

    applyStimulus(8'h00);
    applyStimulus(8'h5A);
    checkOutput("garbageBusy", o_busy, 32'd0);
    frameData = {8'hA5, 8'h77};
    sendFrame(8'h50, 8'h02, 8'h00);
    waitDrain();
    checkOutput("garbageResetPC", o_resetPC, 32'h50);

    frameData.delete();
    for (int i = 0; i < 256; i++) frameData.push_back(8'($urandom_range(0, 255)));
    sendFrame(8'h20, 8'h00, 8'h00);
    waitDrain();
    checkOutput("bigResetPC", o_resetPC, 32'h20);
    checkOutput("bigMcuReset", o_mcuReset, 32'd0);

    applyStimulus(8'hA5);
    applyStimulus(8'h30);
    applyStimulus(8'h05);
    expWr.push_back({8'h30, 8'h9C});
    expWr.push_back({8'h31, 8'h4D});
    applyStimulus(8'h9C);
    applyStimulus(8'h4D);
    repeat (2) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    checkOutput("midRstMcuReset", o_mcuReset, 32'd1);
    checkOutput("midRstBusy", o_busy, 32'd0);
    checkOutput("midRstRxReady", o_rxReady, 32'd0);
    checkOutput("midRstResetPC", o_resetPC, 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

`ifdef IMEM_LOADER_TIMEOUT_EN
    applyStimulus(8'hA5);
    applyStimulus(8'h60);
    applyStimulus(8'h03);
    repeat (20) @(negedge Clk);
    checkOutput("timeoutError", o_error, 32'd1);
    checkOutput("timeoutBusy", o_busy, 32'd0);
    checkOutput("timeoutMcuReset", o_mcuReset, 32'd1);
`endif

    checkOutput("writesLeft", expWr.size(), 32'd0);
    checkOutput("donesLeft", expDone.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
